flop_from_int: RTL and testbench

//  Converts signed integers into the 13-bit "flop" float format consumed by flop_greaterthan
//  and the other flop arithmetic blocks. Format: [12] sign, [11:7] biased exponent (bias 15),
//  [6:0] mantissa with hidden leading 1. All-zero word = zero.

---
 rtl/flop_from_int.sv | 103 ++++++++++
 tb/tb_flop_from_int.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flop_from_int.sv
// Signed integer to 13-bit flop converter: iterative one-bit-per-cycle normaliser, valid/ready both sides.
// Define FLOP_FROM_INT_ROUND_EN for round-to-nearest-even; default build truncates toward zero.
module flop_from_int #(
  parameter int INT_W = 16,
  parameter int EXP_W = 5,
  parameter int MAN_W = 7,
  parameter int BIAS  = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INT_W-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic                   out_ovf
);

  localparam int EW = $clog2(INT_W) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic             sign;
  logic [INT_W-1:0] mag;
  logic [EW-1:0]    expo;

  logic [INT_W-1:0]   abs_in;
  logic [MAN_W-1:0]   man_t;
  logic               rnd;
  logic [MAN_W:0]     man_sum;
  logic [EXP_W:0]     bexp;
  logic               ovf;
  logic [EXP_W+MAN_W:0] pack_word;

  // Unsigned magnitude: the most negative input maps to 2^(INT_W-1) without wrapping.
  assign abs_in = in_data[INT_W-1] ? ('0 - in_data) : in_data;

  assign man_t = mag[INT_W-2 -: MAN_W];

`ifdef FLOP_FROM_INT_ROUND_EN
  logic guard, sticky;
  assign guard  = mag[INT_W-2-MAN_W];
  assign sticky = |mag[INT_W-3-MAN_W:0];
  assign rnd    = guard & (sticky | man_t[0]);
`else
  assign rnd = 1'b0;
`endif

  // A mantissa carry-out leaves the low bits zero and bumps the exponent.
  assign man_sum = {1'b0, man_t} + (MAN_W+1)'(rnd);
  assign bexp    = (EXP_W+1)'(expo) + (EXP_W+1)'(BIAS) + (EXP_W+1)'(man_sum[MAN_W]);
  assign ovf     = bexp >= (EXP_W+1)'((1 << EXP_W) - 1);

  always_comb begin
    pack_word = {sign, bexp[EXP_W-1:0], man_sum[MAN_W-1:0]};
    if (ovf)
      pack_word = {sign, EXP_W'((1 << EXP_W) - 2), {MAN_W{1'b1}}};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sign     <= 1'b0;
      mag      <= '0;
      expo     <= '0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign <= in_data[INT_W-1];
          mag  <= abs_in;
          expo <= EW'(INT_W - 1);
          if (abs_in == '0) begin
            out_data <= '0;
            out_ovf  <= 1'b0;
            state    <= DONE;
          end else begin
            state <= NORM;
          end
        end
        NORM: if (mag[INT_W-1]) begin
          out_data <= pack_word;
          out_ovf  <= ovf;
          state    <= DONE;
        end else begin
          mag  <= mag << 1;
          expo <= expo - EW'(1);
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flop_from_int.sv
// Scoreboard bench for flop_from_int: driver pushes model results, negedge monitor pops and compares.
module tb_flop_from_int;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_data;
  logic        out_ovf;

  flop_from_int dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [12:0] d;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   noise = 0;
  int   stall_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Value-level reference: find the power of two, scale the fraction to MAN_W bits.
  function automatic void model(input logic [15:0] v, output logic [12:0] d,
                                output logic ovf, output int lat);
    int s, m, e, e0, man, b, num;
`ifdef FLOP_FROM_INT_ROUND_EN
    int rem;
`endif
    s = int'(v[15]);
    m = v[15] ? 65536 - int'(v) : int'(v);
    ovf = 1'b0;
    if (m == 0) begin
      d = '0; lat = 1;
      return;
    end
    e = 0;
    while ((1 << (e + 1)) <= m) e++;
    e0  = e;
    num = (m - (1 << e)) * 128;
    man = num / (1 << e);
`ifdef FLOP_FROM_INT_ROUND_EN
    rem = num % (1 << e);
    if (2 * rem > (1 << e) || (2 * rem == (1 << e) && (man % 2) == 1)) man++;
`endif
    if (man == 128) begin man = 0; e++; end
    b = e + 15;
    if (b >= 31) begin
      ovf = 1'b1; d = {s[0], 5'd30, 7'h7f};
    end else begin
      d = {s[0], b[4:0], man[6:0]};
    end
    lat = (15 - e0) + 2;
  endfunction

  function automatic int fkey(input logic [12:0] d);
    int k;
    k = int'(d[11:0]);
    return d[12] ? -k : k;
  endfunction

  task automatic send_exp(input logic [15:0] v, input logic [12:0] d, input logic ovf, input int lat);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready) begin
      in_valid = noise ? 1'($urandom) : 1'b0;
      in_data  = 16'($urandom);
      n++;
      if (n > 300) begin
        in_valid = 1'b0;
        chk("in_ready_timeout", 0, 1);
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = v;
    e.din = v; e.d = d; e.ovf = ovf; e.lat = lat; e.acc = cyc;
    @(posedge clk);
    #1;
    q.push_back(e);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
  endtask

  task automatic send(input logic [15:0] v);
    logic [12:0] d; logic ovf; int lat;
    model(v, d, ovf, lat);
    send_exp(v, d, ovf, lat);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk); n++;
    end
    if (n >= 3000) chk("drain_timeout", 0, 1);
  endtask

  // Monitor
  bit   seen = 0, handed = 0, have_last = 0;
  int   stall_left = 0;
  int   last_in = 0, last_key = 0;
  exp_t cur;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      seen = 0; handed = 0; out_ready = 1'b0;
    end else begin
      if (handed) begin
        chk("handoff_valid_drop", 32'(out_valid), 0);
        chk("handoff_in_ready", 32'(in_ready), 1);
        handed = 0; seen = 0;
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          if (q.size() == 0) begin
            chk("unexpected_output", 0, 1);
            cur.d = out_data; cur.ovf = out_ovf;
          end else begin
            cur = q.pop_front();
            chk("data", 32'(out_data), 32'(cur.d));
            chk("ovf", 32'(out_ovf), 32'(cur.ovf));
            chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
            if (have_last && $signed(cur.din) > last_in)
              chk("monotonic", 32'(fkey(cur.d) >= last_key), 1);
            last_in = $signed(cur.din); last_key = fkey(cur.d); have_last = 1;
          end
          if (stall_req > 0) begin stall_left = stall_req; stall_req = 0; end
        end else begin
          chk("hold_data", 32'(out_data), 32'(cur.d));
          chk("hold_ovf", 32'(out_ovf), 32'(cur.ovf));
        end
        chk("in_ready_in_done", 32'(in_ready), 0);
        if (stall_left > 0) begin
          out_ready = 1'b0; stall_left--;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
        if (out_ready) handed = 1;
      end else begin
        out_ready = 1'($urandom);
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);

    // Directed points with hand-derived results
    send_exp(16'h0001, 13'h0780, 1'b0, 17);
    send_exp(16'hFFFD, 13'h1840, 1'b0, 16);
    send_exp(16'h0000, 13'h0000, 1'b0, 1);
    send_exp(16'h8000, 13'h1F00, 1'b0, 2);
`ifdef FLOP_FROM_INT_ROUND_EN
    send_exp(16'h01FF, 13'h0C00, 1'b0, 9);
`else
    send_exp(16'h01FF, 13'h0BFF, 1'b0, 9);
`endif
    send(16'h7FFF);
    send(16'hFFFF);

    // Stall 5 cycles in DONE while in_valid noise is driven
    stall_req = 5;
    noise = 1;
    send(16'h1234);
    send(16'hC3A5);
    noise = 0;
    drain();

    // Reset mid-NORM: the result must never appear
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    repeat (25) @(negedge clk);
    chk("midrst_no_output", 32'(out_valid), 0);
    have_last = 0;

    // Increasing sweep across the whole range for monotonicity
    for (int v = -32768; v < 32768; v += 97) send(16'(v));
    send(16'h7FFF);
    drain();
    have_last = 0;

    // Random mix of full-range, small and power-of-two neighbourhood values
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 2))
        0: send(16'($urandom));
        1: send(16'($signed($urandom_range(0, 512)) - 256));
        default: send(16'((1 << $urandom_range(0, 15)) + $urandom_range(0, 2) - 1));
      endcase
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
